// File: rtl/e203_exu_longp_retq_pkg.sv
// Shared e203 definitions for the long-pipe retirement queue: datapath width,
// OITF tag width, regfile index width and exception cause encodings.
package e203_exu_longp_retq_pkg;

    localparam int XLEN         = 32;
    localparam int E203_ITAG_W  = 1;
    localparam int E203_RFIDX_W = 5;

    localparam logic [3:0] CAUSE_INSTR_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_LD_MISALGN  = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;

    typedef struct packed {
        logic [XLEN-1:0] badaddr;
        logic [XLEN-1:0] pc;
        logic [3:0]      cause;
    } excp_pl_t;

    function automatic logic cause_is_load(input logic [3:0] cause);
        return (cause == CAUSE_LD_FAULT) || (cause == CAUSE_LD_MISALGN);
    endfunction

    function automatic logic cause_is_insterr(input logic [3:0] cause);
        return cause == CAUSE_INSTR_FAULT;
    endfunction

endpackage

// File: rtl/e203_exu_retq_slot.sv
// One-entry valid/ready pipeline register. Only the valid bit is reset; the
// payload is captured on load and is meaningless while valid is low.
module e203_exu_retq_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dout
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    // Valid sets on load (which wins over a same-cycle drain), clears on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= 1'b0;
        else        vld_q <= load | (vld_q & ~drain);
    end

    // Payload capture, no reset.
    always_ff @(posedge clk) begin
        if (load) dat_q <= din;
    end

    assign vld  = vld_q;
    assign dout = dat_q;

endmodule

// File: rtl/e203_exu_longp_retq.sv
// Long-pipe retirement queue: picks the LSU or MulDiv result matching the OITF
// head tag, retires it, and stages either a write-back or an exception.
module e203_exu_longp_retq
    import e203_exu_longp_retq_pkg::*;
#(
    parameter int RFIDX_W = E203_RFIDX_W,
    parameter int ITAG_W  = E203_ITAG_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               lsu_i_valid,
    output logic               lsu_i_ready,
    input  logic [XLEN-1:0]    lsu_i_wdat,
    input  logic [ITAG_W-1:0]  lsu_i_itag,
    input  logic               lsu_i_err,
    input  logic [XLEN-1:0]    lsu_i_badaddr,
    input  logic               lsu_i_buserr,

    input  logic               md_i_valid,
    output logic               md_i_ready,
    input  logic [XLEN-1:0]    md_i_wdat,
    input  logic [ITAG_W-1:0]  md_i_itag,

    input  logic               oitf_empty,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic               oitf_ret_rdwen,
    input  logic               oitf_ret_rdfpu,
    input  logic [XLEN-1:0]    oitf_ret_pc,
    output logic               oitf_ret_ena,

    output logic               longp_wbck_o_valid,
    input  logic               longp_wbck_o_ready,
    output logic [XLEN-1:0]    longp_wbck_o_wdat,
    output logic [4:0]         longp_wbck_o_flags,
    output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
    output logic               longp_wbck_o_rdfpu,

    output logic               longp_excp_o_valid,
    input  logic               longp_excp_o_ready,
    output logic               longp_excp_o_insterr,
    output logic               longp_excp_o_ld,
    output logic [XLEN-1:0]    longp_excp_o_badaddr,
    output logic [XLEN-1:0]    longp_excp_o_pc
);

    localparam int WB_W = XLEN + RFIDX_W + 1;

    logic               lsu_elig, md_elig, sel_lsu, sel_md;
    logic               wb_vld, excp_vld, can_load, accept, sel_err;
    logic               wb_load, excp_load;
    logic [WB_W-1:0]    wb_din, wb_dout;
    excp_pl_t           excp_din, excp_dout;

    // Bus errors are reported as load access faults; the raw flag carries no
    // extra information here.
    logic unused_buserr;
    assign unused_buserr = lsu_i_buserr;

    // In-order eligibility and LSU-first selection.
    always_comb begin
        lsu_elig = lsu_i_valid & ~oitf_empty & (lsu_i_itag == oitf_ret_ptr);
        md_elig  = md_i_valid  & ~oitf_empty & (md_i_itag  == oitf_ret_ptr);
        sel_lsu  = lsu_elig;
        sel_md   = md_elig & ~lsu_elig;
    end

    // Handshake: a slot can take a new entry only if no exception is pending
    // and the write-back slot is empty or draining this cycle. Readies are
    // forced low while reset is held.
    always_comb begin
        can_load    = rst_n & ~excp_vld & (~wb_vld | longp_wbck_o_ready);
        lsu_i_ready = sel_lsu & can_load;
        md_i_ready  = sel_md  & can_load;
        accept      = lsu_i_ready | md_i_ready;
        sel_err     = sel_lsu & lsu_i_err;
        wb_load     = accept & ~sel_err & oitf_ret_rdwen;
        excp_load   = accept & sel_err;
    end

    assign oitf_ret_ena = accept;

    // Payload muxing into the two slots.
    always_comb begin
        wb_din           = {(sel_lsu ? lsu_i_wdat : md_i_wdat), oitf_ret_rdidx, oitf_ret_rdfpu};
        excp_din.badaddr = lsu_i_badaddr;
        excp_din.pc      = oitf_ret_pc;
        excp_din.cause   = CAUSE_LD_FAULT;
    end

    e203_exu_retq_slot #(.W(WB_W)) u_wb_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (wb_load),
        .drain (longp_wbck_o_ready),
        .din   (wb_din),
        .vld   (wb_vld),
        .dout  (wb_dout)
    );

    e203_exu_retq_slot #(.W($bits(excp_pl_t))) u_excp_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (excp_load),
        .drain (longp_excp_o_ready),
        .din   (excp_din),
        .vld   (excp_vld),
        .dout  (excp_dout)
    );

    // Output mapping straight from the slot flops.
    always_comb begin
        longp_wbck_o_valid   = wb_vld;
        {longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_wbck_o_rdfpu} = wb_dout;
        longp_wbck_o_flags   = 5'b0;
        longp_excp_o_valid   = excp_vld;
        longp_excp_o_badaddr = excp_dout.badaddr;
        longp_excp_o_pc      = excp_dout.pc;
        longp_excp_o_ld      = cause_is_load(excp_dout.cause);
        longp_excp_o_insterr = cause_is_insterr(excp_dout.cause);
    end

endmodule

// File: tb/tb_e203_exu_longp_retq.sv
// Bench for the long-pipe retirement queue: scenario tasks plus a scoreboard
// that checks every write-back / exception handshake against queued entries.
module tb_e203_exu_longp_retq;

    typedef struct packed {
        logic [31:0] wdat;
        logic [4:0]  rdidx;
        logic        rdfpu;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] badaddr;
        logic [31:0] pc;
    } ex_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_i_valid, lsu_i_ready, lsu_i_err, lsu_i_buserr;
    logic [31:0] lsu_i_wdat, lsu_i_badaddr;
    logic [0:0]  lsu_i_itag;
    logic        md_i_valid, md_i_ready;
    logic [31:0] md_i_wdat;
    logic [0:0]  md_i_itag;
    logic        oitf_empty, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena;
    logic [0:0]  oitf_ret_ptr;
    logic [4:0]  oitf_ret_rdidx;
    logic [31:0] oitf_ret_pc;
    logic        longp_wbck_o_valid, longp_wbck_o_ready, longp_wbck_o_rdfpu;
    logic [31:0] longp_wbck_o_wdat;
    logic [4:0]  longp_wbck_o_flags, longp_wbck_o_rdidx;
    logic        longp_excp_o_valid, longp_excp_o_ready, longp_excp_o_insterr, longp_excp_o_ld;
    logic [31:0] longp_excp_o_badaddr, longp_excp_o_pc;

    int checks = 0;
    int errors = 0;
    wb_exp_t wb_q[$];
    ex_exp_t ex_q[$];

    always #5 clk = ~clk;

    e203_exu_longp_retq dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_i_valid(lsu_i_valid), .lsu_i_ready(lsu_i_ready), .lsu_i_wdat(lsu_i_wdat),
        .lsu_i_itag(lsu_i_itag), .lsu_i_err(lsu_i_err), .lsu_i_badaddr(lsu_i_badaddr),
        .lsu_i_buserr(lsu_i_buserr),
        .md_i_valid(md_i_valid), .md_i_ready(md_i_ready), .md_i_wdat(md_i_wdat), .md_i_itag(md_i_itag),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu), .oitf_ret_pc(oitf_ret_pc),
        .oitf_ret_ena(oitf_ret_ena),
        .longp_wbck_o_valid(longp_wbck_o_valid), .longp_wbck_o_ready(longp_wbck_o_ready),
        .longp_wbck_o_wdat(longp_wbck_o_wdat), .longp_wbck_o_flags(longp_wbck_o_flags),
        .longp_wbck_o_rdidx(longp_wbck_o_rdidx), .longp_wbck_o_rdfpu(longp_wbck_o_rdfpu),
        .longp_excp_o_valid(longp_excp_o_valid), .longp_excp_o_ready(longp_excp_o_ready),
        .longp_excp_o_insterr(longp_excp_o_insterr), .longp_excp_o_ld(longp_excp_o_ld),
        .longp_excp_o_badaddr(longp_excp_o_badaddr), .longp_excp_o_pc(longp_excp_o_pc)
    );

    // Scoreboard: every handshake seen mid-cycle must match the oldest entry.
    always @(negedge clk) begin
        wb_exp_t we;
        ex_exp_t ee;
        if (longp_wbck_o_valid === 1'b1 && longp_wbck_o_ready === 1'b1) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got wdat=%h rdidx=%0d, no entry expected", longp_wbck_o_wdat, longp_wbck_o_rdidx);
            end else begin
                we = wb_q.pop_front();
                if ({longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_wbck_o_rdfpu, longp_wbck_o_flags} !== {we.wdat, we.rdidx, we.rdfpu, 5'b0}) begin
                    errors++;
                    $display("FAIL wb_data: got wdat=%h rdidx=%0d rdfpu=%b flags=%b, want wdat=%h rdidx=%0d rdfpu=%b flags=00000",
                             longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_wbck_o_rdfpu, longp_wbck_o_flags, we.wdat, we.rdidx, we.rdfpu);
                end
            end
        end
        if (longp_excp_o_valid === 1'b1 && longp_excp_o_ready === 1'b1) begin
            checks++;
            if (ex_q.size() == 0) begin
                errors++;
                $display("FAIL excp_unexpected: got badaddr=%h pc=%h, no entry expected", longp_excp_o_badaddr, longp_excp_o_pc);
            end else begin
                ee = ex_q.pop_front();
                if ({longp_excp_o_badaddr, longp_excp_o_pc, longp_excp_o_ld, longp_excp_o_insterr} !== {ee.badaddr, ee.pc, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL excp_data: got badaddr=%h pc=%h ld=%b insterr=%b, want badaddr=%h pc=%h ld=1 insterr=0",
                             longp_excp_o_badaddr, longp_excp_o_pc, longp_excp_o_ld, longp_excp_o_insterr, ee.badaddr, ee.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        lsu_i_valid = 0; lsu_i_err = 0; lsu_i_buserr = 0; lsu_i_wdat = 0; lsu_i_badaddr = 0; lsu_i_itag = 0;
        md_i_valid = 0; md_i_wdat = 0; md_i_itag = 0;
        oitf_ret_ptr = 0; oitf_ret_rdidx = 0; oitf_ret_rdwen = 1; oitf_ret_rdfpu = 0; oitf_ret_pc = 0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (wb_q.size() == 0 && ex_q.size() == 0) break;
            tick();
        end
        checks++;
        if (wb_q.size() != 0 || ex_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending wb=%0d excp=%0d, want 0 0", wb_q.size(), ex_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); oitf_empty = 0;
        longp_wbck_o_ready = 1; longp_excp_o_ready = 1;
        md_i_valid = 1; lsu_i_valid = 1; lsu_i_itag = 1;
        #3;
        checks++;
        if ({longp_wbck_o_valid, longp_excp_o_valid, md_i_ready, lsu_i_ready, oitf_ret_ena} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got wbv/exv/mdr/lsur/ena=%b, want 00000",
                     {longp_wbck_o_valid, longp_excp_o_valid, md_i_ready, lsu_i_ready, oitf_ret_ena});
        end
        tick(); tick();
        checks++;
        if ({longp_wbck_o_valid, md_i_ready, oitf_ret_ena} !== 3'b0) begin
            errors++;
            $display("FAIL reset_hold: got wbv/mdr/ena=%b, want 000", {longp_wbck_o_valid, md_i_ready, oitf_ret_ena});
        end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_md_basic();
        tick();
        oitf_ret_rdidx = 3; oitf_ret_pc = 32'h40;
        md_i_valid = 1; md_i_itag = 0; md_i_wdat = 32'h1234;
        #1;
        checks++;
        if ({md_i_ready, oitf_ret_ena} !== 2'b11) begin
            errors++;
            $display("FAIL md_accept: got ready/ena=%b, want 11", {md_i_ready, oitf_ret_ena});
        end
        wb_q.push_back('{32'h1234, 5'd3, 1'b0});
        tick();
        md_i_valid = 0;
        #1;
        checks++;
        if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_wdat !== 32'h1234) begin
            errors++;
            $display("FAIL md_latency: got valid=%b wdat=%h, want 1 00001234", longp_wbck_o_valid, longp_wbck_o_wdat);
        end
        wait_drain(5);
    endtask

    task automatic test_priority();
        tick();
        oitf_ret_ptr = 0; oitf_ret_rdidx = 7; oitf_ret_rdfpu = 0;
        md_i_valid = 1; md_i_itag = 0; md_i_wdat = 32'hA1;
        lsu_i_valid = 1; lsu_i_itag = 1; lsu_i_wdat = 32'hB1;
        #1;
        checks++;
        if ({md_i_ready, lsu_i_ready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_itag: got md/lsu ready=%b, want 10", {md_i_ready, lsu_i_ready});
        end
        wb_q.push_back('{32'hA1, 5'd7, 1'b0});
        tick();
        oitf_ret_ptr = 1; oitf_ret_rdidx = 8; oitf_ret_rdfpu = 1;
        md_i_itag = 1; md_i_wdat = 32'hA2;
        #1;
        checks++;
        if ({lsu_i_ready, md_i_ready, oitf_ret_ena, longp_wbck_o_valid} !== 4'b1011) begin
            errors++;
            $display("FAIL prio_lsu_first: got lsur/mdr/ena/wbv=%b, want 1011",
                     {lsu_i_ready, md_i_ready, oitf_ret_ena, longp_wbck_o_valid});
        end
        wb_q.push_back('{32'hB1, 5'd8, 1'b1});
        tick();
        idle_inputs();
        wait_drain(5);
    endtask

    task automatic test_excp();
        tick();
        longp_excp_o_ready = 0;
        oitf_ret_pc = 32'h100; oitf_ret_rdidx = 4;
        lsu_i_valid = 1; lsu_i_itag = 0; lsu_i_err = 1; lsu_i_badaddr = 32'h8000_0004; lsu_i_wdat = 32'hDEAD;
        #1;
        checks++;
        if ({lsu_i_ready, oitf_ret_ena} !== 2'b11) begin
            errors++;
            $display("FAIL excp_accept: got ready/ena=%b, want 11", {lsu_i_ready, oitf_ret_ena});
        end
        ex_q.push_back('{32'h8000_0004, 32'h100});
        tick();
        lsu_i_valid = 0; lsu_i_err = 0;
        oitf_ret_pc = 32'h104; oitf_ret_ptr = 1;
        md_i_valid = 1; md_i_itag = 1; md_i_wdat = 32'hC3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({longp_excp_o_valid, longp_excp_o_ld, longp_excp_o_insterr, longp_wbck_o_valid, md_i_ready, oitf_ret_ena} !== 6'b110000 ||
                longp_excp_o_badaddr !== 32'h8000_0004 || longp_excp_o_pc !== 32'h100) begin
                errors++;
                $display("FAIL excp_hold[%0d]: got exv/ld/ie/wbv/mdr/ena=%b badaddr=%h pc=%h, want 110000 80000004 00000100", i,
                         {longp_excp_o_valid, longp_excp_o_ld, longp_excp_o_insterr, longp_wbck_o_valid, md_i_ready, oitf_ret_ena},
                         longp_excp_o_badaddr, longp_excp_o_pc);
            end
            tick();
        end
        longp_excp_o_ready = 1;
        #1;
        checks++;
        if (md_i_ready !== 1'b0) begin
            errors++;
            $display("FAIL excp_drain_block: got md_ready=%b, want 0", md_i_ready);
        end
        tick();
        #1;
        checks++;
        if ({longp_excp_o_valid, md_i_ready, oitf_ret_ena} !== 3'b011) begin
            errors++;
            $display("FAIL excp_release: got exv/mdr/ena=%b, want 011", {longp_excp_o_valid, md_i_ready, oitf_ret_ena});
        end
        wb_q.push_back('{32'hC3, 5'd4, 1'b0});
        tick();
        idle_inputs();
        wait_drain(5);
    endtask

    task automatic test_stall();
        tick();
        longp_wbck_o_ready = 0;
        oitf_ret_rdidx = 9;
        md_i_valid = 1; md_i_itag = 0; md_i_wdat = 32'hD4;
        #1;
        checks++;
        if (md_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: got md_ready=%b, want 1", md_i_ready);
        end
        wb_q.push_back('{32'hD4, 5'd9, 1'b0});
        tick();
        oitf_ret_ptr = 1; oitf_ret_rdidx = 10;
        md_i_itag = 1; md_i_wdat = 32'hE5;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({md_i_ready, oitf_ret_ena, longp_wbck_o_valid} !== 3'b001 ||
                longp_wbck_o_wdat !== 32'hD4 || longp_wbck_o_rdidx !== 5'd9) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got mdr/ena/wbv=%b wdat=%h rdidx=%0d, want 001 000000d4 9", i,
                         {md_i_ready, oitf_ret_ena, longp_wbck_o_valid}, longp_wbck_o_wdat, longp_wbck_o_rdidx);
            end
            tick();
        end
        longp_wbck_o_ready = 1;
        #1;
        checks++;
        if ({md_i_ready, oitf_ret_ena} !== 2'b11) begin
            errors++;
            $display("FAIL stall_drain_load: got ready/ena=%b, want 11", {md_i_ready, oitf_ret_ena});
        end
        wb_q.push_back('{32'hE5, 5'd10, 1'b0});
        tick();
        idle_inputs();
        #1;
        checks++;
        if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_wdat !== 32'hE5) begin
            errors++;
            $display("FAIL stall_reload: got valid=%b wdat=%h, want 1 000000e5", longp_wbck_o_valid, longp_wbck_o_wdat);
        end
        wait_drain(5);
    endtask

    task automatic test_no_rdwen();
        tick();
        oitf_ret_rdwen = 0;
        md_i_valid = 1; md_i_itag = 0; md_i_wdat = 32'h77;
        #1;
        checks++;
        if ({md_i_ready, oitf_ret_ena} !== 2'b11) begin
            errors++;
            $display("FAIL nowen_md_accept: got ready/ena=%b, want 11", {md_i_ready, oitf_ret_ena});
        end
        tick();
        md_i_valid = 0;
        lsu_i_valid = 1; lsu_i_itag = 0; lsu_i_wdat = 32'h88;
        #1;
        checks++;
        if ({longp_wbck_o_valid, lsu_i_ready, oitf_ret_ena} !== 3'b011) begin
            errors++;
            $display("FAIL nowen_md_retire: got wbv/lsur/ena=%b, want 011", {longp_wbck_o_valid, lsu_i_ready, oitf_ret_ena});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (longp_wbck_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL nowen_lsu_retire: got wbck_valid=%b, want 0", longp_wbck_o_valid);
        end
    endtask

    task automatic test_async_reset();
        tick();
        longp_wbck_o_ready = 0;
        md_i_valid = 1; md_i_itag = 0; md_i_wdat = 32'h55;
        tick();
        md_i_valid = 0;
        #1;
        checks++;
        if (longp_wbck_o_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_wb_setup: got wbck_valid=%b, want 1", longp_wbck_o_valid);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({longp_wbck_o_valid, longp_excp_o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL areset_wb: got wbv/exv=%b, want 00", {longp_wbck_o_valid, longp_excp_o_valid});
        end
        tick();
        rst_n = 1;
        longp_wbck_o_ready = 1; longp_excp_o_ready = 0;
        lsu_i_valid = 1; lsu_i_itag = 0; lsu_i_err = 1; lsu_i_badaddr = 32'h66;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (longp_excp_o_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_excp_setup: got excp_valid=%b, want 1", longp_excp_o_valid);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({longp_wbck_o_valid, longp_excp_o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL areset_excp: got wbv/exv=%b, want 00", {longp_wbck_o_valid, longp_excp_o_valid});
        end
        tick();
        rst_n = 1;
        longp_excp_o_ready = 1;
    endtask

    initial begin
        test_reset();
        test_md_basic();
        test_priority();
        test_excp();
        test_stall();
        test_no_rdwen();
        test_async_reset();
        tick(); tick();
        checks++;
        if (wb_q.size() != 0 || ex_q.size() != 0) begin
            errors++;
            $display("FAIL final_queues: pending wb=%0d excp=%0d, want 0 0", wb_q.size(), ex_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e203_exu_longp_retq.md
E203_EXU_LONGP_RETQ -- requirements
Module: e203_exu_longp_retq

Interface
REQ-001 SHALL have parameter RFIDX_W, default 5, giving the regfile index width.
REQ-002 SHALL have parameter ITAG_W, default 1, giving the OITF pointer width for a 2-entry OITF.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have LSU inputs lsu_i_valid (1), lsu_i_wdat (32), lsu_i_itag (ITAG_W), lsu_i_err (1), lsu_i_badaddr (32), lsu_i_buserr (1), and output lsu_i_ready (1).
REQ-006 SHALL have MulDiv inputs md_i_valid (1), md_i_wdat (32), md_i_itag (ITAG_W), and output md_i_ready (1); MulDiv never errs.
REQ-007 SHALL have OITF head inputs oitf_empty (1), oitf_ret_ptr (ITAG_W), oitf_ret_rdidx (RFIDX_W), oitf_ret_rdwen (1), oitf_ret_rdfpu (1), oitf_ret_pc (32), and output oitf_ret_ena (1).
REQ-008 SHALL have write-back outputs longp_wbck_o_valid (1), longp_wbck_o_wdat (32), longp_wbck_o_flags (5), longp_wbck_o_rdidx (RFIDX_W), longp_wbck_o_rdfpu (1), and input longp_wbck_o_ready (1).
REQ-009 SHALL have exception outputs longp_excp_o_valid (1), longp_excp_o_insterr (1), longp_excp_o_ld (1), longp_excp_o_badaddr (32), longp_excp_o_pc (32), and input longp_excp_o_ready (1).

Function
REQ-010 SHALL treat a source as eligible only when its valid is 1, oitf_empty is 0, and its itag equals oitf_ret_ptr (in-order retirement).
REQ-011 SHALL give LSU priority over MulDiv when both are eligible in the same cycle.
REQ-012 SHALL define can_load = ~excp_vld & (~wb_vld | longp_wbck_o_ready).
REQ-013 SHALL drive the selected source's ready = can_load; the non-selected or ineligible source's ready SHALL be 0.
REQ-014 SHALL define accept = selected valid & ready, and SHALL pulse oitf_ret_ena = accept in the same cycle.
REQ-015 SHALL, on accept with err=0 and oitf_ret_rdwen=1, load the WB register next edge: wdat, rdidx, rdfpu, wb_vld=1.
REQ-016 SHALL, on accept with err=0 and oitf_ret_rdwen=0, retire the instruction only; wb_vld clears if drained.
REQ-017 SHALL, on accept with LSU err=1, load the EXCP register (badaddr, pc=oitf_ret_pc, ld=1, insterr=0), set excp_vld=1, and suppress any write-back.
REQ-018 SHALL clear wb_vld on longp_wbck_o_ready when no new load occurs; a simultaneous drain and load SHALL keep wb_vld=1 with new data.
REQ-019 SHALL hold excp_vld and its payload stable until longp_excp_o_ready=1, then clear it; no accept SHALL occur while excp_vld=1.
REQ-020 SHALL drive longp_wbck_o_valid=wb_vld and longp_excp_o_valid=excp_vld directly from flops (latency 1 cycle accept-to-output).
REQ-021 SHALL drive longp_wbck_o_flags=5'b0 always.
REQ-022 SHALL sustain one retirement per cycle when longp_wbck_o_ready is held at 1.
REQ-023 SHALL hold outputs stable while valid=1 and ready=0.

Reset
REQ-024 SHALL asynchronously clear wb_vld and excp_vld to 0 on rst_n=0, including mid-handshake.
REQ-025 SHALL hold all payload registers free of reset; payload is loaded only on accept and is don't-care when not valid.
REQ-026 SHALL keep oitf_ret_ena and all readies at 0 during reset.

Structure
REQ-027 SHALL take XLEN=32, the ITAG width and the EXCP cause encodings from the shared e203 defines package.
REQ-028 SHALL use one sub-module, e203_exu_retq_slot, a 1-entry valid/ready pipeline register instantiated for both WB and EXCP.

Verification
REQ-029 SHALL cover: OITF ptr=0, rdwen=1, md_i_valid itag=0 wdat=0x1234 -> oitf_ret_ena pulse; next cycle wbck_valid=1, wdat=0x1234.
REQ-030 SHALL cover: both sources valid with LSU itag=1, MD itag=0, ptr=0 -> MD accepted, lsu_i_ready=0.
REQ-031 SHALL cover: LSU err=1, badaddr=0x8000_0004, pc=0x100 -> excp_valid=1 with those values, no wbck_valid; holds 3 cycles with excp_ready=0; no accepts.
REQ-032 SHALL cover: wbck_ready=0 with wb_vld=1 and a new eligible source -> source ready=0; on ready=1 the drain and load occur in the same cycle.
REQ-033 SHALL cover: rdwen=0 accept -> oitf_ret_ena=1, wbck_valid stays 0.
REQ-034 SHALL cover: rst_n asserted while wb_vld=1 and excp_vld=1 -> both valids 0 immediately, before the next clock edge.
